// File: rtl/fare_validator_if.sv
// fare_validator_if: groups the card reader, turnstile guard and station
// controller signals of the fare validator into one bundle.
//   master modport : the environment side (card reader / guard / controller);
//                    drives card_tap, card_balance, unblock.
//   slave modport  : the fare_validator side; drives valid_pay, charge_we,
//                    new_balance, deny, busy, fault, trip_cnt, revenue.
// BAL_W and CNT_W must match the parameters of the attached fare_validator.
interface fare_validator_if #(
    parameter int BAL_W = 16,
    parameter int CNT_W = 16
);
    logic             card_tap;
    logic [BAL_W-1:0] card_balance;
    logic             unblock;
    logic             valid_pay;
    logic             charge_we;
    logic [BAL_W-1:0] new_balance;
    logic             deny;
    logic             busy;
    logic             fault;
    logic [CNT_W-1:0] trip_cnt;
    logic [CNT_W-1:0] revenue;

    modport master (
        output card_tap, card_balance, unblock,
        input  valid_pay, charge_we, new_balance, deny, busy, fault,
               trip_cnt, revenue
    );

    modport slave (
        input  card_tap, card_balance, unblock,
        output valid_pay, charge_we, new_balance, deny, busy, fault,
               trip_cnt, revenue
    );
endinterface

// File: rtl/fare_validator.sv
// fare_validator: payment-side controller for a metro turnstile.
// A card tap is checked against FARE; on success the card is debited
// (charge_we/new_balance), the guard gets a one-cycle valid_pay strobe and the
// unlock/relock session is followed through unblock. A guard that never
// unlocks within ACK_TIMEOUT cycles parks the block in a sticky FAULT state.
// Completed trips and collected fares are kept in saturating counters.
// Ports:
//   clk  - system clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - fare_validator_if.slave (card_tap, card_balance, unblock in;
//          valid_pay, charge_we, new_balance, deny, busy, fault,
//          trip_cnt, revenue out)
module fare_validator #(
    parameter int BAL_W       = 16,
    parameter int FARE        = 50,
    parameter int ACK_TIMEOUT = 8,
    parameter int CNT_W       = 16
) (
    input  logic            clk,
    input  logic            rst,
    fare_validator_if.slave bus
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);
    localparam logic [BAL_W-1:0] FARE_B   = BAL_W'(FARE);
    localparam logic [CNT_W:0]   FARE_C   = (CNT_W+1)'(FARE);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_DENY      = 3'd2,
        ST_PAY       = 3'd3,
        ST_WAIT_ACK  = 3'd4,
        ST_WAIT_DONE = 3'd5,
        ST_FAULT     = 3'd6
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [BAL_W-1:0] bal_r;
    logic [BAL_W-1:0] new_bal_r;
    logic [TMR_W-1:0] timer_r;
    logic [CNT_W-1:0] trip_r;
    logic [CNT_W-1:0] rev_r;
    logic             funds_ok_s;
    logic             relock_s;
    logic [CNT_W:0]   trip_sum_s;
    logic [CNT_W:0]   rev_sum_s;
    logic [CNT_W-1:0] trip_nxt_s;
    logic [CNT_W-1:0] rev_nxt_s;
    logic             valid_pay_s;
    logic             charge_we_s;
    logic             deny_s;
    logic             busy_s;
    logic             fault_s;

    assign funds_ok_s = (bal_r >= FARE_B);
    // The session ends on the first cycle the guard relocks after unlocking.
    assign relock_s   = (state_r == ST_WAIT_DONE) && !bus.unblock;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; taps outside IDLE are simply not looked at.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (bus.card_tap) state_nxt_s = ST_CHECK;
                else              state_nxt_s = ST_IDLE;
            end
            ST_CHECK: begin
                if (funds_ok_s) state_nxt_s = ST_PAY;
                else            state_nxt_s = ST_DENY;
            end
            ST_DENY:  state_nxt_s = ST_IDLE;
            ST_PAY:   state_nxt_s = ST_WAIT_ACK;
            ST_WAIT_ACK: begin
                if (bus.unblock)              state_nxt_s = ST_WAIT_DONE;
                else if (timer_r == TMR_LAST) state_nxt_s = ST_FAULT;
                else                          state_nxt_s = ST_WAIT_ACK;
            end
            ST_WAIT_DONE: begin
                if (!bus.unblock) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_WAIT_DONE;
            end
            ST_FAULT: state_nxt_s = ST_FAULT;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Moore output decode from the state register.
    always_comb begin
        valid_pay_s = 1'b0;
        charge_we_s = 1'b0;
        deny_s      = 1'b0;
        fault_s     = 1'b0;
        case (state_r)
            ST_PAY: begin
                valid_pay_s = 1'b1;
                charge_we_s = 1'b1;
            end
            ST_DENY:  deny_s  = 1'b1;
            ST_FAULT: fault_s = 1'b1;
            default: begin
                valid_pay_s = 1'b0;
                charge_we_s = 1'b0;
                deny_s      = 1'b0;
                fault_s     = 1'b0;
            end
        endcase
        busy_s = (state_r != ST_IDLE);
    end

    // Saturating next values for the station counters (one extra carry bit).
    always_comb begin
        trip_sum_s = {1'b0, trip_r} + (CNT_W+1)'(1);
        rev_sum_s  = {1'b0, rev_r} + FARE_C;
        if (trip_sum_s[CNT_W]) trip_nxt_s = '1;
        else                   trip_nxt_s = trip_sum_s[CNT_W-1:0];
        if (rev_sum_s[CNT_W])  rev_nxt_s  = '1;
        else                   rev_nxt_s  = rev_sum_s[CNT_W-1:0];
    end

    // Datapath: balance capture, debit, acknowledge timer and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bal_r     <= '0;
            new_bal_r <= '0;
            timer_r   <= '0;
            trip_r    <= '0;
            rev_r     <= '0;
        end else begin
            if ((state_r == ST_IDLE) && bus.card_tap) begin
                bal_r <= bus.card_balance;
            end
            // Debit lands on the CHECK->PAY edge so it is valid during PAY.
            if ((state_r == ST_CHECK) && funds_ok_s) begin
                new_bal_r <= bal_r - FARE_B;
            end
            if (state_r == ST_PAY) begin
                timer_r <= '0;
            end else if ((state_r == ST_WAIT_ACK) && !bus.unblock && (timer_r != TMR_LAST)) begin
                timer_r <= timer_r + TMR_W'(1);
            end
            if (relock_s) begin
                trip_r <= trip_nxt_s;
                rev_r  <= rev_nxt_s;
            end
        end
    end

    assign bus.valid_pay   = valid_pay_s;
    assign bus.charge_we   = charge_we_s;
    assign bus.deny        = deny_s;
    assign bus.busy        = busy_s;
    assign bus.fault       = fault_s;
    assign bus.new_balance = new_bal_r;
    assign bus.trip_cnt    = trip_r;
    assign bus.revenue     = rev_r;

endmodule
